// File: rtl/rfsched_pkg.sv
// Shared types and sizing helpers for the register-file write scheduler.
package rfsched_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } entry_t;

    function automatic int cnt_w(int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rfsched_if.sv
// Writer, drain and hazard signals between the scheduler and its neighbours.
interface rfsched_if
    import rfsched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          wb_val;
    logic          wb_rdy;
    logic [AW-1:0] wb_a;
    logic [DW-1:0] wb_d;
    logic          lnk_val;
    logic          lnk_rdy;
    logic [AW-1:0] lnk_a;
    logic [DW-1:0] lnk_pc;
    logic          hold;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          haz1;
    logic          haz2;
    logic          byp1;
    logic          byp2;
    logic [DW-1:0] bd1;
    logic [DW-1:0] bd2;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic          empty;

    modport master (
        output wb_val, wb_a, wb_d, lnk_val, lnk_a, lnk_pc, hold, ra1, ra2,
        input  wb_rdy, lnk_rdy, haz1, haz2, byp1, byp2, bd1, bd2, we3, a3, wd3, empty
    );

    modport slave (
        input  wb_val, wb_a, wb_d, lnk_val, lnk_a, lnk_pc, hold, ra1, ra2,
        output wb_rdy, lnk_rdy, haz1, haz2, byp1, byp2, bd1, bd2, we3, a3, wd3, empty
    );

endinterface

// File: rtl/rfsched_queue.sv
// Dual-push, single-pop circular buffer; exposes an age-ordered view ([0] = head).
module rfsched_queue
    import rfsched_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type ent_t = entry_t,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push0_i,
    input  ent_t             push0_ent_i,
    input  logic             push1_i,
    input  ent_t             push1_ent_i,
    input  logic             pop_i,
    output logic [CW-1:0]    count_o,
    output ent_t             ent_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    ent_t          mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [1:0]    n_push;
    ent_t          first_ent;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] p, int inc);
        int s;
        s = int'(p) + inc;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign n_push    = {1'b0, push0_i} + {1'b0, push1_i};
    assign first_ent = push0_i ? push0_ent_i : push1_ent_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push0_i || push1_i) mem_q[tail_q] <= first_ent;
            if (push0_i && push1_i) mem_q[wrap_add(tail_q, 1)] <= push1_ent_i;
            tail_q  <= wrap_add(tail_q, int'(n_push));
            if (pop_i) head_q <= wrap_add(head_q, 1);
            count_q <= count_q + CW'(n_push) - CW'(pop_i);
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_o[j]   = mem_q[wrap_add(head_q, j)];
            valid_o[j] = (j < int'(count_q));
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_write_sched.sv
// Arbitrates WB and jump-link writes onto the single register-file write port.
// Optional forwarding of youngest pending data is enabled by RFSCHED_BYPASS_EN.
module regfile_write_sched
    import rfsched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input logic       clk_i,
    input logic       rst_n_i,
    rfsched_if.slave  bus
);

    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic [CW-1:0]    q_count;
    ent_t             q_ent [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic             rdy;
    logic             push0;
    logic             push1;
    ent_t             push0_ent;
    ent_t             push1_ent;
    logic             pop;
    logic             we3_q;
    logic [AW-1:0]    a3_q;
    logic [DW-1:0]    wd3_q;
    logic [AW-1:0]    ra [2];
    logic [1:0]       hit;

    // Room for two pushes is guaranteed whenever ready is high.
    assign rdy       = (int'(q_count) <= DEPTH - 2);
    assign push0     = bus.wb_val  && rdy && (bus.wb_a  != AW'(REG_ZERO));
    assign push1     = bus.lnk_val && rdy && (bus.lnk_a != AW'(REG_ZERO));
    assign push0_ent = '{addr: bus.wb_a,  data: bus.wb_d};
    assign push1_ent = '{addr: bus.lnk_a, data: bus.lnk_pc + DW'(1)};
    assign pop       = !bus.hold && (q_count != '0);

    rfsched_queue #(
        .DEPTH (DEPTH),
        .ent_t (ent_t)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push0_i     (push0),
        .push0_ent_i (push0_ent),
        .push1_i     (push1),
        .push1_ent_i (push1_ent),
        .pop_i       (pop),
        .count_o     (q_count),
        .ent_o       (q_ent),
        .valid_o     (q_valid)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= pop;
            if (pop) begin
                a3_q  <= q_ent[0].addr;
                wd3_q <= q_ent[0].data;
            end
        end
    end

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    // The output stage counts as pending until RegisterFile has committed it.
    always_comb begin
        hit = '0;
        for (int n = 0; n < 2; n++) begin
            if (ra[n] != AW'(REG_ZERO)) begin
                if (we3_q && (a3_q == ra[n])) hit[n] = 1'b1;
                for (int j = 0; j < DEPTH; j++)
                    if (q_valid[j] && (q_ent[j].addr == ra[n])) hit[n] = 1'b1;
            end
        end
    end

`ifdef RFSCHED_BYPASS_EN
    logic [DW-1:0] bd [2];
    logic [1:0]    byp;

    // Oldest first, so the youngest match overwrites and wins.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            bd[n] = '0;
            if (ra[n] != AW'(REG_ZERO)) begin
                if (we3_q && (a3_q == ra[n])) bd[n] = wd3_q;
                for (int j = 0; j < DEPTH; j++)
                    if (q_valid[j] && (q_ent[j].addr == ra[n])) bd[n] = q_ent[j].data;
            end
        end
    end

    assign byp      = hit;
    assign bus.byp1 = byp[0];
    assign bus.byp2 = byp[1];
    assign bus.bd1  = bd[0];
    assign bus.bd2  = bd[1];
    assign bus.haz1 = hit[0] & ~byp[0];
    assign bus.haz2 = hit[1] & ~byp[1];
`else
    logic unused_ent_data;

    always_comb begin
        unused_ent_data = 1'b0;
        for (int j = 0; j < DEPTH; j++) unused_ent_data = unused_ent_data ^ (^q_ent[j].data);
    end

    assign bus.byp1 = 1'b0;
    assign bus.byp2 = 1'b0;
    assign bus.bd1  = '0;
    assign bus.bd2  = '0;
    assign bus.haz1 = hit[0];
    assign bus.haz2 = hit[1];
`endif

    assign bus.wb_rdy  = rdy;
    assign bus.lnk_rdy = rdy;
    assign bus.we3     = we3_q;
    assign bus.a3      = a3_q;
    assign bus.wd3     = wd3_q;
    assign bus.empty   = (q_count == '0) && !we3_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched (DEPTH=4); bypass expectations follow RFSCHED_BYPASS_EN.
module tb_regfile_write_sched;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    rfsched_if #(.AW(AW), .DW(DW)) bus ();

    regfile_write_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_val  = 1'b0;
        bus.wb_a    = '0;
        bus.wb_d    = '0;
        bus.lnk_val = 1'b0;
        bus.lnk_a   = '0;
        bus.lnk_pc  = '0;
        bus.hold    = 1'b0;
        bus.ra1     = '0;
        bus.ra2     = '0;
    endtask

    task automatic test_reset();
        bus.ra1 = 5'd5;
        #1;
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL reset_we3: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.a3 !== 5'd0)    $display("FAIL reset_a3: got %0d want 0", bus.a3); else passed++;
        checks++; if (bus.wd3 !== 32'd0)  $display("FAIL reset_wd3: got %h want 0", bus.wd3); else passed++;
        checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", bus.empty); else passed++;
        checks++; if (bus.wb_rdy !== 1'b1) $display("FAIL reset_wb_rdy: got %0b want 1", bus.wb_rdy); else passed++;
        checks++; if (bus.lnk_rdy !== 1'b1) $display("FAIL reset_lnk_rdy: got %0b want 1", bus.lnk_rdy); else passed++;
        checks++; if (bus.haz1 !== 1'b0)  $display("FAIL reset_haz1: got %0b want 0", bus.haz1); else passed++;
        checks++; if (bus.byp1 !== 1'b0)  $display("FAIL reset_byp1: got %0b want 0", bus.byp1); else passed++;
        checks++; if (bus.bd1 !== 32'd0)  $display("FAIL reset_bd1: got %h want 0", bus.bd1); else passed++;
        bus.ra1 = '0;
    endtask

    task automatic test_single_wb();
        bus.wb_val = 1'b1; bus.wb_a = 5'd5; bus.wb_d = 32'hDEADBEEF; bus.ra1 = 5'd5;
        tick();
        bus.wb_val = 1'b0;
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL single_we3_k: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL single_haz1_queued: got %0b want 1", bus.haz1); else passed++;
        checks++; if (bus.empty !== 1'b0) $display("FAIL single_empty_k: got %0b want 0", bus.empty); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b1)   $display("FAIL single_we3_k1: got %0b want 1", bus.we3); else passed++;
        checks++; if (bus.a3 !== 5'd5)    $display("FAIL single_a3: got %0d want 5", bus.a3); else passed++;
        checks++; if (bus.wd3 !== 32'hDEADBEEF) $display("FAIL single_wd3: got %h want deadbeef", bus.wd3); else passed++;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL single_haz1_out: got %0b want 1", bus.haz1); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL single_we3_done: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.a3 !== 5'd5)    $display("FAIL single_a3_hold: got %0d want 5", bus.a3); else passed++;
        checks++; if (bus.haz1 !== 1'b0)  $display("FAIL single_haz1_done: got %0b want 0", bus.haz1); else passed++;
        checks++; if (bus.empty !== 1'b1) $display("FAIL single_empty_done: got %0b want 1", bus.empty); else passed++;
        bus.ra1 = '0;
    endtask

    task automatic test_dual_push();
        bus.wb_val = 1'b1; bus.wb_a = 5'd31; bus.wb_d = 32'd7;
        bus.lnk_val = 1'b1; bus.lnk_a = 5'd31; bus.lnk_pc = 32'h40;
        bus.ra1 = 5'd31;
        tick();
        bus.wb_val = 1'b0; bus.lnk_val = 1'b0;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL dual_haz1_q: got %0b want 1", bus.haz1); else passed++;
        checks++; if (bus.wb_rdy !== 1'b1) $display("FAIL dual_rdy_cnt2: got %0b want 1", bus.wb_rdy); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b1)   $display("FAIL dual_we3_1: got %0b want 1", bus.we3); else passed++;
        checks++; if (bus.a3 !== 5'd31)   $display("FAIL dual_a3_1: got %0d want 31", bus.a3); else passed++;
        checks++; if (bus.wd3 !== 32'd7)  $display("FAIL dual_wd3_1: got %h want 7", bus.wd3); else passed++;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL dual_haz1_1: got %0b want 1", bus.haz1); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b1)   $display("FAIL dual_we3_2: got %0b want 1", bus.we3); else passed++;
        checks++; if (bus.wd3 !== 32'h41) $display("FAIL dual_wd3_2: got %h want 41", bus.wd3); else passed++;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL dual_haz1_2: got %0b want 1", bus.haz1); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL dual_we3_done: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.haz1 !== 1'b0)  $display("FAIL dual_haz1_done: got %0b want 0", bus.haz1); else passed++;
        bus.ra1 = '0;
    endtask

    task automatic test_back_to_back();
        bus.wb_val = 1'b1; bus.wb_a = 5'd10; bus.wb_d = 32'd100;
        tick();
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL b2b_we3_0: got %0b want 0", bus.we3); else passed++;
        bus.wb_val = 1'b0;
        bus.lnk_val = 1'b1; bus.lnk_a = 5'd11; bus.lnk_pc = 32'hFFFFFFFF;
        bus.ra2 = 5'd11;
        tick();
        bus.lnk_val = 1'b0;
        checks++; if (bus.we3 !== 1'b1)   $display("FAIL b2b_we3_1: got %0b want 1", bus.we3); else passed++;
        checks++; if (bus.a3 !== 5'd10)   $display("FAIL b2b_a3_1: got %0d want 10", bus.a3); else passed++;
        checks++; if (bus.wd3 !== 32'd100) $display("FAIL b2b_wd3_1: got %h want 64", bus.wd3); else passed++;
        checks++; if (bus.haz2 !== 1'b1)  $display("FAIL b2b_haz2_q: got %0b want 1", bus.haz2); else passed++;
        tick();
        checks++; if (bus.a3 !== 5'd11)   $display("FAIL b2b_a3_2: got %0d want 11", bus.a3); else passed++;
        checks++; if (bus.wd3 !== 32'd0)  $display("FAIL b2b_pc_wrap: got %h want 0", bus.wd3); else passed++;
        checks++; if (bus.haz2 !== 1'b1)  $display("FAIL b2b_haz2_out: got %0b want 1", bus.haz2); else passed++;
        tick();
        checks++; if (bus.haz2 !== 1'b0)  $display("FAIL b2b_haz2_done: got %0b want 0", bus.haz2); else passed++;
        checks++; if (bus.empty !== 1'b1) $display("FAIL b2b_empty: got %0b want 1", bus.empty); else passed++;
        bus.ra2 = '0;
    endtask

    task automatic test_full_hold();
        bus.hold = 1'b1;
        bus.wb_val = 1'b1;
        bus.ra1 = 5'd2;
        for (int a = 1; a <= 3; a++) begin
            bus.wb_a = 5'(a);
            bus.wb_d = 32'(a * 16);
            checks++; if (bus.wb_rdy !== 1'b1) $display("FAIL full_rdy_pre%0d: got %0b want 1", a, bus.wb_rdy); else passed++;
            tick();
        end
        checks++; if (bus.wb_rdy !== 1'b0)  $display("FAIL full_wb_rdy: got %0b want 0", bus.wb_rdy); else passed++;
        checks++; if (bus.lnk_rdy !== 1'b0) $display("FAIL full_lnk_rdy: got %0b want 0", bus.lnk_rdy); else passed++;
        checks++; if (bus.we3 !== 1'b0)     $display("FAIL full_hold_we3: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.haz1 !== 1'b1)    $display("FAIL full_hold_haz1: got %0b want 1", bus.haz1); else passed++;
        bus.wb_a = 5'd4; bus.wb_d = 32'h99;
        tick();
        checks++; if (bus.wb_rdy !== 1'b0)  $display("FAIL full_rdy_stuck: got %0b want 0", bus.wb_rdy); else passed++;
        bus.wb_val = 1'b0;
        bus.hold = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.we3 !== 1'b1)       $display("FAIL full_drain_we3_%0d: got %0b want 1", i, bus.we3); else passed++;
            checks++; if (bus.a3 !== 5'(i))       $display("FAIL full_drain_a3_%0d: got %0d want %0d", i, bus.a3, i); else passed++;
            checks++; if (bus.wd3 !== 32'(i * 16)) $display("FAIL full_drain_wd3_%0d: got %h want %h", i, bus.wd3, i * 16); else passed++;
            checks++; if (bus.wb_rdy !== 1'b1)    $display("FAIL full_drain_rdy_%0d: got %0b want 1", i, bus.wb_rdy); else passed++;
        end
        tick();
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL full_no_reject_write: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.empty !== 1'b1) $display("FAIL full_empty: got %0b want 1", bus.empty); else passed++;
        bus.ra1 = '0;
    endtask

    task automatic test_zero_reg();
        bus.wb_val = 1'b1; bus.wb_a = 5'd0; bus.wb_d = 32'h55; bus.ra1 = 5'd0;
        checks++; if (bus.wb_rdy !== 1'b1) $display("FAIL zero_rdy: got %0b want 1", bus.wb_rdy); else passed++;
        tick();
        bus.wb_val = 1'b0;
        checks++; if (bus.empty !== 1'b1) $display("FAIL zero_empty: got %0b want 1", bus.empty); else passed++;
        checks++; if (bus.haz1 !== 1'b0)  $display("FAIL zero_haz1: got %0b want 0", bus.haz1); else passed++;
        tick();
        checks++; if (bus.we3 !== 1'b0)   $display("FAIL zero_we3: got %0b want 0", bus.we3); else passed++;
    endtask

    task automatic test_bypass();
        bus.hold = 1'b1;
        bus.wb_val = 1'b1; bus.wb_a = 5'd3; bus.wb_d = 32'd1;
        tick();
        bus.wb_d = 32'd2;
        tick();
        bus.wb_val = 1'b0;
        bus.ra1 = 5'd3; bus.ra2 = 5'd3;
        #1;
`ifdef RFSCHED_BYPASS_EN
        checks++; if (bus.byp1 !== 1'b1)  $display("FAIL byp_byp1: got %0b want 1", bus.byp1); else passed++;
        checks++; if (bus.bd1 !== 32'd2)  $display("FAIL byp_bd1: got %h want 2", bus.bd1); else passed++;
        checks++; if (bus.haz1 !== 1'b0)  $display("FAIL byp_haz1: got %0b want 0", bus.haz1); else passed++;
        checks++; if (bus.bd2 !== 32'd2)  $display("FAIL byp_bd2: got %h want 2", bus.bd2); else passed++;
`else
        checks++; if (bus.byp1 !== 1'b0)  $display("FAIL byp_byp1: got %0b want 0", bus.byp1); else passed++;
        checks++; if (bus.bd1 !== 32'd0)  $display("FAIL byp_bd1: got %h want 0", bus.bd1); else passed++;
        checks++; if (bus.haz1 !== 1'b1)  $display("FAIL byp_haz1: got %0b want 1", bus.haz1); else passed++;
        checks++; if (bus.haz2 !== 1'b1)  $display("FAIL byp_haz2: got %0b want 1", bus.haz2); else passed++;
`endif
        bus.hold = 1'b0;
        tick();
        checks++; if (bus.wd3 !== 32'd1)  $display("FAIL byp_drain_1: got %h want 1", bus.wd3); else passed++;
        tick();
        checks++; if (bus.wd3 !== 32'd2)  $display("FAIL byp_drain_2: got %h want 2", bus.wd3); else passed++;
        tick();
        checks++; if (bus.empty !== 1'b1) $display("FAIL byp_empty: got %0b want 1", bus.empty); else passed++;
        bus.ra1 = '0; bus.ra2 = '0;
    endtask

    task automatic test_reset_mid();
        bus.hold = 1'b1;
        bus.wb_val = 1'b1;
        for (int a = 7; a <= 9; a++) begin
            bus.wb_a = 5'(a);
            bus.wb_d = 32'(a * 16);
            tick();
        end
        bus.wb_val = 1'b0;
        bus.hold = 1'b0;
        bus.ra1 = 5'd8;
        tick();
        checks++; if (bus.we3 !== 1'b1)   $display("FAIL rmid_we3_pre: got %0b want 1", bus.we3); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.we3 !== 1'b0)    $display("FAIL rmid_we3: got %0b want 0", bus.we3); else passed++;
        checks++; if (bus.empty !== 1'b1)  $display("FAIL rmid_empty: got %0b want 1", bus.empty); else passed++;
        checks++; if (bus.wb_rdy !== 1'b1) $display("FAIL rmid_rdy: got %0b want 1", bus.wb_rdy); else passed++;
        checks++; if (bus.haz1 !== 1'b0)   $display("FAIL rmid_haz1: got %0b want 0", bus.haz1); else passed++;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.we3 !== 1'b0) $display("FAIL rmid_stale_%0d: got %0b want 0", i, bus.we3); else passed++;
        end
        checks++; if (bus.empty !== 1'b1) $display("FAIL rmid_empty_after: got %0b want 1", bus.empty); else passed++;
        bus.ra1 = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        test_reset();
        #9;
        rst_n = 1'b1;
        tick();
        test_single_wb();
        test_dual_push();
        test_back_to_back();
        test_full_hold();
        test_zero_reg();
        test_bypass();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
